img_stream_gen: RTL and testbench
=================================

IMG_STREAM_GEN -- requirements
Module: img_stream_gen

Interface
REQ-001 The block SHALL have parameter IMG_HDISP, default 640, meaning active pixels per row.
REQ-002 The block SHALL have parameter IMG_VDISP, default 480, meaning active rows per frame.
REQ-003 The block SHALL have parameter H_BLANK, default 10, meaning href-low cycles before each row (at least 1).
REQ-004 The block SHALL have parameter V_FRONT, default 5, meaning cycles from vsync rise to the first row's blanking.
REQ-005 The block SHALL have parameter V_BACK, default 1, meaning cycles after the last pixel before vsync falls.
REQ-006 The block SHALL have the following ports:
- clk  in  1  sole clock, rising edge;
- rst  in  1  synchronous, active-high reset;
- start  in  1  single-cycle frame request;
- busy  out  1  high while a frame is in progress;
- frame_done  out  1  one-cycle pulse when a frame ends;
- rd_en  out  1  pixel memory read strobe;
- rd_addr  out  $clog2(IMG_HDISP*IMG_VDISP)  pixel address, row-major;
- rd_data  in  8  read data, valid one cycle after rd_en;
- img_vsync  out  1  frame valid;
- img_href  out  1  pixel valid;
- img_gray  out  8  pixel value.

Function
REQ-007 The FSM SHALL have the states IDLE, VFRONT, HBLANK, ACTIVE and VBACK.
REQ-008 IDLE SHALL go to VFRONT on start=1; start SHALL be ignored in every other state.
REQ-009 VFRONT SHALL last V_FRONT cycles and then go to HBLANK.
REQ-010 HBLANK SHALL last H_BLANK cycles and then go to ACTIVE.
REQ-011 ACTIVE SHALL last IMG_HDISP cycles, then go to HBLANK if rows remain, else to VBACK.
REQ-012 VBACK SHALL last V_BACK cycles and then go to IDLE; V_FRONT=0 or V_BACK=0 SHALL skip that state.
REQ-013 rd_en SHALL be 1 exactly in ACTIVE cycles.
REQ-014 rd_addr SHALL be 0 at the first ACTIVE cycle of a frame and increment by 1 per rd_en.
REQ-015 Internal vsync SHALL be 1 in every non-IDLE state, and internal href SHALL equal rd_en.
REQ-016 img_vsync and img_href SHALL be internal vsync and href delayed by exactly 2 registered cycles.
REQ-017 img_gray SHALL be rd_data registered in the cycle it is valid, aligned with img_href.
REQ-018 img_gray SHALL be 0 whenever img_href=0.
REQ-019 Pixel latency SHALL be rd_en at cycle N -> img_href/img_gray at cycle N+2.
REQ-020 img_vsync high time SHALL be V_FRONT + IMG_VDISP*(H_BLANK+IMG_HDISP) + V_BACK cycles.
REQ-021 busy SHALL be 1 from the cycle after start is accepted until the cycle img_vsync falls.
REQ-022 frame_done SHALL pulse in the cycle img_vsync falls.
REQ-023 A start received in the same cycle frame_done pulses SHALL be ignored; the next frame SHALL need start in IDLE with busy=0.
REQ-024 The column and row counters SHALL wrap to 0 at the end of each row and frame; rd_addr SHALL never exceed IMG_HDISP*IMG_VDISP-1.

Reset
REQ-025 With rst=1 at a clock edge, the FSM SHALL go to IDLE, all counters and pipeline registers SHALL clear, and every output SHALL be 0 the next cycle.
REQ-026 A reset mid-frame SHALL abort the frame without a frame_done pulse, and a start is required afterwards.

Configuration
REQ-027 With macro IMG_STREAM_GEN_PATTERN_EN defined, the block SHALL add input port pattern_en (1 bit), sampled at frame start.
REQ-028 With pattern_en=1, img_gray SHALL be (row+col) mod 256, rd_en SHALL stay 0, and timing SHALL be unchanged.
REQ-029 Without the macro, the pattern_en port and logic SHALL be absent and pixels SHALL always come from memory.

Verification
(Parameters: IMG_HDISP=4, IMG_VDISP=3, H_BLANK=5, V_FRONT=5, V_BACK=2; memory holds addr+8'h10.)
REQ-030 Single start -> img_vsync high 34 cycles; 3 href bursts of 4 with 5 low between; img_gray 10,11,...,1B; one frame_done.
REQ-031 rd_en at cycle N -> img_href at N+2 with img_gray = rd_addr(N)+8'h10; rd_addr never exceeds 11.
REQ-032 start pulses while busy=1 -> ignored; exactly one frame; back-to-back start after frame_done -> second identical frame with rd_addr restarting at 0.
REQ-033 rst=1 in row 2 of ACTIVE -> next cycle all outputs 0, no frame_done; start -> full correct frame.
REQ-034 With the macro defined and pattern_en=1 -> row 0 gives 0,1,2,3 and row 2 gives 2,3,4,5; rd_en never asserted.

Source files
------------

// File: rtl/img_stream_gen.sv
// -----------------------------------------------------------------------------
// img_stream_gen
//
// Streams one frame of 8-bit grayscale pixels on request. The frame is built
// from a V_FRONT lead-in, IMG_VDISP rows of (H_BLANK idle + IMG_HDISP active)
// cycles, and a V_BACK tail. During active cycles the block reads pixel memory
// in row-major order. The video outputs are the internal sync/valid signals
// delayed by two registers, so that they line up with the memory read data.
//
// Parameters:
//   IMG_HDISP  active pixels per row
//   IMG_VDISP  active rows per frame
//   H_BLANK    href-low cycles before each row (>= 1)
//   V_FRONT    cycles from vsync rise to the first row's blanking (0 = none)
//   V_BACK     cycles after the last pixel before vsync falls   (0 = none)
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous, active-high reset
//   start       single-cycle frame request (accepted only when idle, busy=0)
//   pattern_en  (IMG_STREAM_GEN_PATTERN_EN only) test-pattern select,
//               sampled when start is accepted
//   busy        high from the cycle after start until img_vsync falls
//   frame_done  one-cycle pulse in the cycle img_vsync falls
//   rd_en       pixel memory read strobe
//   rd_addr     pixel address, row-major
//   rd_data     read data, valid one cycle after rd_en
//   img_vsync   frame valid
//   img_href    pixel valid
//   img_gray    pixel value, 0 whenever img_href=0
//
// Optional feature: define IMG_STREAM_GEN_PATTERN_EN to add pattern_en. When
// a frame starts with pattern_en=1, pixels are (row+col) mod 256 instead of
// memory data, rd_en stays low, and timing is unchanged.
// -----------------------------------------------------------------------------
module img_stream_gen #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_BLANK   = 10,
    parameter int V_FRONT   = 5,
    parameter int V_BACK    = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
`ifdef IMG_STREAM_GEN_PATTERN_EN
    input  logic                                    pattern_en,
`endif
    output logic                                    busy,
    output logic                                    frame_done,
    output logic                                    rd_en,
    output logic [$clog2(IMG_HDISP*IMG_VDISP)-1:0]  rd_addr,
    input  logic [7:0]                              rd_data,
    output logic                                    img_vsync,
    output logic                                    img_href,
    output logic [7:0]                              img_gray
);

    localparam int NPIX    = IMG_HDISP * IMG_VDISP;
    localparam int AW      = $clog2(NPIX);
    localparam int M1      = (V_FRONT > H_BLANK) ? V_FRONT : H_BLANK;
    localparam int M2      = (V_BACK > IMG_HDISP) ? V_BACK : IMG_HDISP;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int ROW_W   = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VFRONT = 3'd1,
        HBLANK = 3'd2,
        ACTIVE = 3'd3,
        VBACK  = 3'd4
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;       // phase counter; column index in ACTIVE
    logic [ROW_W-1:0]   row, row_d;
    logic               accept;
    logic               vsync_int;
    logic               href_int;
    logic               pat_mode;

    // Pipeline: stage p0 is one cycle after the read strobe (rd_data valid),
    // stage p1 drives the video outputs.
    logic               vsync_p0, vsync_p1;
    logic               vld_p0, vld_p1;
    logic [7:0]         gray_p1;
    logic [7:0]         gray_src;
    logic               done_q;

    // Test-pattern pixel value; the sum is taken wide and wrapped to 8 bits.
    function automatic logic [7:0] pat_pix(input logic [ROW_W-1:0] r,
                                           input logic [CNT_W-1:0] c);
        logic [31:0] s;
        s = 32'(r) + 32'(c);
        return s[7:0];
    endfunction

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        row_d   = row;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                row_d = '0;
                // busy also covers the output-pipeline drain and the
                // frame_done cycle, so start is ignored until fully idle.
                if (start && !busy) begin
                    accept  = 1'b1;
                    state_d = (V_FRONT > 0) ? VFRONT : HBLANK;
                end
            end
            VFRONT: begin
                if (cnt == CNT_W'(V_FRONT - 1)) begin
                    cnt_d   = '0;
                    state_d = HBLANK;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            HBLANK: begin
                if (cnt == CNT_W'(H_BLANK - 1)) begin
                    cnt_d   = '0;
                    state_d = ACTIVE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (cnt == CNT_W'(IMG_HDISP - 1)) begin
                    cnt_d = '0;
                    if (row == ROW_W'(IMG_VDISP - 1)) begin
                        row_d   = '0;
                        state_d = (V_BACK > 0) ? VBACK : IDLE;
                    end else begin
                        row_d   = row + ROW_W'(1);
                        state_d = HBLANK;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            VBACK: begin
                if (cnt == CNT_W'(V_BACK - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                row_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            row   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            row   <= row_d;
        end
    end

    assign vsync_int = (state != IDLE);
    assign href_int  = (state == ACTIVE);
    assign rd_en     = href_int && !pat_mode;

`ifdef IMG_STREAM_GEN_PATTERN_EN
    logic [7:0] pat_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_mode <= 1'b0;
            pat_p0   <= '0;
        end else begin
            if (accept) pat_mode <= pattern_en;
            pat_p0 <= pat_pix(row, cnt);
        end
    end

    assign gray_src = pat_mode ? pat_p0 : rd_data;
`else
    assign pat_mode = 1'b0;
    assign gray_src = rd_data;
`endif

    // Address wraps after the last pixel so the next frame restarts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr <= '0;
        end else if (rd_en) begin
            if (rd_addr == AW'(NPIX - 1)) rd_addr <= '0;
            else                          rd_addr <= rd_addr + AW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stage p0: read data arrives
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_p0 <= 1'b0;
            vld_p0   <= 1'b0;
        end else begin
            vsync_p0 <= vsync_int;
            vld_p0   <= href_int;
        end
    end

    // ------------------------------------------------------------------
    // Stage p1: video outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_p1 <= 1'b0;
            vld_p1   <= 1'b0;
            gray_p1  <= '0;
            done_q   <= 1'b0;
        end else begin
            vsync_p1 <= vsync_p0;
            vld_p1   <= vld_p0;
            gray_p1  <= vld_p0 ? gray_src : 8'd0;
            // Registered fall detect lands exactly in the cycle img_vsync drops.
            done_q   <= vsync_p1 && !vsync_p0;
        end
    end

    assign img_vsync  = vsync_p1;
    assign img_href   = vld_p1;
    assign img_gray   = gray_p1;
    assign frame_done = done_q;
    assign busy       = vsync_int | vsync_p0 | vsync_p1 | done_q;

endmodule

// File: tb/tb_img_stream_gen.sv
module tb_img_stream_gen;

    localparam int HD = 4, VD = 3, HB = 5, VF = 5, VB = 2;
    localparam int FRAME_K = 38;   // cycles 0..37 observed after start accepted

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, frame_done, rd_en, img_vsync, img_href;
    logic [3:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] img_gray;
`ifdef IMG_STREAM_GEN_PATTERN_EN
    logic       pattern_en = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    img_stream_gen #(
        .IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB), .V_FRONT(VF), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef IMG_STREAM_GEN_PATTERN_EN
        .pattern_en(pattern_en),
`endif
        .busy(busy), .frame_done(frame_done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .img_vsync(img_vsync), .img_href(img_href),
        .img_gray(img_gray)
    );

    always #5 clk = ~clk;

    // Pixel memory: contents are addr+8'h10, one cycle read latency.
    // Junk value when not reading exposes misaligned sampling.
    always @(posedge clk) rd_data <= rd_en ? ({4'h0, rd_addr} + 8'h10) : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame geometry model: k counts cycles after the start-accept edge.
    function automatic bit act_at(input int k, output int r, output int c);
        int f, p;
        r = 0; c = 0;
        f = k - VF;
        if (f < 0 || f >= VD * (HB + HD)) return 1'b0;
        r = f / (HB + HD);
        p = f % (HB + HD);
        if (p < HB) return 1'b0;
        c = p - HB;
        return 1'b1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},  32'(busy), 0);
        chk({tag, ".done"},  32'(frame_done), 0);
        chk({tag, ".rden"},  32'(rd_en), 0);
        chk({tag, ".vsync"}, 32'(img_vsync), 0);
        chk({tag, ".href"},  32'(img_href), 0);
        chk({tag, ".gray"},  32'(img_gray), 0);
    endtask

    // Called at a negedge; requests a frame and checks every cycle of it.
    // inj0/inj1 are cycles at which an extra start is driven (must be ignored).
    task automatic run_frame(input int inj0, input int inj1, input bit pat);
        int  r, c, r2, c2;
        bit  a, a2;
        logic [7:0] g;
`ifdef IMG_STREAM_GEN_PATTERN_EN
        pattern_en = pat;
`endif
        start = 1'b1;
        for (int k = 0; k < FRAME_K; k++) begin
            @(negedge clk);
            start = (k == inj0) || (k == inj1);
`ifdef IMG_STREAM_GEN_PATTERN_EN
            pattern_en = 1'b0;
`endif
            a  = act_at(k, r, c);
            a2 = act_at(k - 2, r2, c2);
            g  = pat ? 8'(r2 + c2) : 8'(8'h10 + r2 * HD + c2);
            chk($sformatf("k%0d.vsync", k), 32'(img_vsync), 32'(k >= 2 && k <= 35));
            chk($sformatf("k%0d.busy", k),  32'(busy),      32'(k <= 36));
            chk($sformatf("k%0d.done", k),  32'(frame_done), 32'(k == 36));
            chk($sformatf("k%0d.rden", k),  32'(rd_en),     32'(a && !pat));
            chk($sformatf("k%0d.href", k),  32'(img_href),  32'(a2));
            chk($sformatf("k%0d.gray", k),  32'(img_gray),  a2 ? 32'(g) : 0);
            chk($sformatf("k%0d.addrmax", k), 32'(rd_addr <= 4'd11), 1);
            if (a && !pat)
                chk($sformatf("k%0d.addr", k), 32'(rd_addr), 32'(r * HD + c));
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst.addr", 32'(rd_addr), 0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_rst");

        // Frame 1 with extra starts mid-frame and in the frame_done cycle
        run_frame(10, 36, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk_idle("after_f1");
        end

        // Back-to-back: frame 2, then frame 3 requested in the first idle cycle
        run_frame(-1, -1, 1'b0);
        run_frame(-1, -1, 1'b0);

        // Mid-frame reset in row 2 active (k=29 is row 2, col 1)
        start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst.rden", 32'(rd_en), 1);
        chk("pre_rst.addr", 32'(rd_addr), 9);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("midrst");
        chk("midrst.addr", 32'(rd_addr), 0);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk_idle("midrst_after");
        end
        run_frame(-1, -1, 1'b0);

`ifdef IMG_STREAM_GEN_PATTERN_EN
        // Test pattern frame, then a memory frame to confirm pattern_en is per-frame
        run_frame(-1, -1, 1'b1);
        run_frame(-1, -1, 1'b0);
`endif

        @(negedge clk);
        chk_idle("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety bound against a hung sequence.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
